// File: rtl/module_imm_gen_stage_if.sv
// Handshake bundle for the decode-stage immediate generator.
// The upstream/downstream driver uses the master modport and the stage uses slave.
interface module_imm_gen_stage_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [24:0]       instr_i;
    logic [2:0]        imm_src_i;
    logic [TAG_W-1:0]  tag_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [XLEN-1:0]   imm_ext_o;
    logic [TAG_W-1:0]  tag_o;
    logic              imm_err_o;

    modport master (
        output flush_i, in_valid_i, instr_i, imm_src_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, imm_ext_o, tag_o, imm_err_o
    );

    modport slave (
        input  flush_i, in_valid_i, instr_i, imm_src_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, imm_ext_o, tag_o, imm_err_o
    );
endinterface

// File: rtl/module_imm_gen_stage.sv
// Registered immediate generator with a 2-entry skid buffer.
// Decodes I/S/B/J/U/CSR-zimm/shamt immediates on the way in, stores them extended,
// and presents them with their tag through a valid/ready output port.
module module_imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    module_imm_gen_stage_if.slave bus
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("module_imm_gen_stage: XLEN must be 32 or 64");
    end
    if ($bits(bus.imm_ext_o) != XLEN || $bits(bus.tag_o) != TAG_W) begin : g_bad_if
        $error("module_imm_gen_stage: interface parameters do not match the stage");
    end

    typedef enum logic [2:0] {
        FMT_I  = 3'b000,
        FMT_S  = 3'b001,
        FMT_B  = 3'b010,
        FMT_J  = 3'b011,
        FMT_U  = 3'b100,
        FMT_Z  = 3'b101,
        FMT_SH = 3'b110,
        FMT_X  = 3'b111
    } fmt_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    // Instruction bits indexed with their architectural positions.
    logic [31:7] ins;
    assign ins = bus.instr_i;

    logic [31:0] imm32;
    logic        err_new;
    entry_t      entry_new;

    // Decode the immediate into a 32-bit value already sign-extended where the format requires it.
    // NOTE: every variable written in this block gets a default first so no latch is inferred.
    always_comb begin
        imm32   = '0;
        err_new = 1'b0;
        unique case (fmt_e'(bus.imm_src_i))
            FMT_I:  imm32 = {{20{ins[31]}}, ins[31:20]};
            FMT_S:  imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:  imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_J:  imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            FMT_U:  imm32 = {ins[31:12], 12'b0};
            FMT_Z:  imm32 = {27'b0, ins[19:15]};
            FMT_SH: imm32 = (XLEN == 32) ? {27'b0, ins[24:20]} : {26'b0, ins[25:20]};
            FMT_X:  err_new = 1'b1;
            default: err_new = 1'b1;
        endcase
    end

    // Zero-extended formats have bit 31 clear, so one sign-extension covers every format.
    assign entry_new.imm = XLEN'(signed'(imm32));
    assign entry_new.tag = bus.tag_i;
    assign entry_new.err = err_new;

    state_e state_q, state_d;
    entry_t main_q, skid_q;
    logic   acc, pop;
    logic   load_main_in, load_main_skid, load_skid;

    assign bus.in_ready_o  = (state_q != FULL);
    assign bus.out_valid_o = (state_q != EMPTY);
    assign bus.imm_ext_o   = main_q.imm;
    assign bus.tag_o       = main_q.tag;
    assign bus.imm_err_o   = main_q.err;

    assign acc = bus.in_valid_i & bus.in_ready_o & ~bus.flush_i;
    assign pop = bus.out_valid_o & bus.out_ready_i;

    // Next-state and slot-load decode for the skid buffer.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (acc) begin
                    load_main_in = 1'b1;
                    state_d      = ONE;
                end
            end
            ONE: begin
                if (acc && pop) begin
                    load_main_in = 1'b1;
                end else if (acc) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    load_main_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (bus.flush_i) begin
            state_d = EMPTY;
        end
    end

    // State register; reset wins over flush and accept.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Main slot drives the outputs; it is cleared on reset so the outputs read zero afterwards.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q <= '0;
        end else if (load_main_in) begin
            main_q <= entry_new;
        end else if (load_main_skid) begin
            main_q <= skid_q;
        end
    end

    // Skid slot only ever feeds the main slot after being written.
    // NOTE: no reset here; its contents are never visible until loaded, so a reset would only cost flops.
    always_ff @(posedge clk_i) begin
        if (load_skid) begin
            skid_q <= entry_new;
        end
    end

endmodule

// File: tb/tb_module_imm_gen_stage.sv
// Self-checking bench for module_imm_gen_stage at XLEN 32 and 64 in lockstep.
// A queue-based reference model tracks contents; immediates come from field arithmetic.
module tb_module_imm_gen_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    module_imm_gen_stage_if #(.XLEN(32), .TAG_W(32)) if32 ();
    module_imm_gen_stage_if #(.XLEN(64), .TAG_W(32)) if64 ();

    module_imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if32)
    );

    module_imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if64)
    );

    typedef struct {
        logic [63:0] imm32;
        logic [63:0] imm64;
        logic [31:0] tag;
        bit          err;
    } exp_t;

    exp_t q[$];
    bit   zero_exp;
    int   n_checks = 0;
    int   n_pass   = 0;

    bit          cur_v, cur_fl, cur_rdy, cur_r;
    logic [24:0] cur_f;
    logic [2:0]  cur_src;
    logic [31:0] cur_tag;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, got, exp, $time);
    endtask

    function automatic longint unsigned fld(input longint unsigned w, input int hi, input int lo);
        return (w >> lo) & ((64'd1 << (hi - lo + 1)) - 64'd1);
    endfunction

    // Immediate as the instruction-set rules define it, built from field arithmetic.
    function automatic logic [63:0] ref_imm(input logic [24:0] f, input logic [2:0] src,
                                            input int xlen, output bit err);
        longint unsigned w, v;
        int width;
        bit sgn;
        w = {32'b0, f, 7'b0};
        v = 0; width = 32; sgn = 1'b1; err = 1'b0;
        case (src)
            3'd0: begin v = fld(w, 31, 20); width = 12; end
            3'd1: begin v = (fld(w, 31, 25) << 5) | fld(w, 11, 7); width = 12; end
            3'd2: begin
                v = (fld(w, 31, 31) << 12) | (fld(w, 7, 7) << 11) |
                    (fld(w, 30, 25) << 5) | (fld(w, 11, 8) << 1);
                width = 13;
            end
            3'd3: begin
                v = (fld(w, 31, 31) << 20) | (fld(w, 19, 12) << 12) |
                    (fld(w, 20, 20) << 11) | (fld(w, 30, 21) << 1);
                width = 21;
            end
            3'd4: begin v = fld(w, 31, 12) << 12; width = 32; end
            3'd5: begin v = fld(w, 19, 15); sgn = 1'b0; end
            3'd6: begin v = (xlen == 32) ? fld(w, 24, 20) : fld(w, 25, 20); sgn = 1'b0; end
            default: begin v = 0; sgn = 1'b0; err = 1'b1; end
        endcase
        if (sgn && v[width-1]) v = v - (64'd1 << width);
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    function automatic logic [24:0] hi25(input logic [31:0] word);
        return word[31:7];
    endfunction

    task automatic drive(input bit v, input logic [24:0] f, input logic [2:0] src,
                         input logic [31:0] tag, input bit fl, input bit rdy, input bit r);
        cur_v = v; cur_f = f; cur_src = src; cur_tag = tag;
        cur_fl = fl; cur_rdy = rdy; cur_r = r;
        rst = r;
        if32.in_valid_i = v;  if64.in_valid_i = v;
        if32.instr_i    = f;  if64.instr_i    = f;
        if32.imm_src_i  = src; if64.imm_src_i = src;
        if32.tag_i      = tag; if64.tag_i     = tag;
        if32.flush_i    = fl; if64.flush_i    = fl;
        if32.out_ready_i = rdy; if64.out_ready_i = rdy;
    endtask

    task automatic compare_all();
        check("valid32", if32.out_valid_o, q.size() > 0);
        check("ready32", if32.in_ready_o,  q.size() < 2);
        check("valid64", if64.out_valid_o, q.size() > 0);
        check("ready64", if64.in_ready_o,  q.size() < 2);
        if (q.size() > 0) begin
            check("imm32", if32.imm_ext_o, q[0].imm32);
            check("imm64", if64.imm_ext_o, q[0].imm64);
            check("tag32", if32.tag_o, q[0].tag);
            check("tag64", if64.tag_o, q[0].tag);
            check("err32", if32.imm_err_o, q[0].err);
            check("err64", if64.imm_err_o, q[0].err);
        end else if (zero_exp) begin
            check("rst_imm32", if32.imm_ext_o, 0);
            check("rst_imm64", if64.imm_ext_o, 0);
            check("rst_tag32", if32.tag_o, 0);
            check("rst_err32", if32.imm_err_o, 0);
        end
    endtask

    // One clock: predict handshakes from the model, advance it at the edge, compare at negedge.
    task automatic step();
        bit   acc, pop, e;
        exp_t ent;
        acc = cur_v && (q.size() < 2) && !cur_fl;
        pop = (q.size() > 0) && cur_rdy;
        ent.imm32 = ref_imm(cur_f, cur_src, 32, e);
        ent.imm64 = ref_imm(cur_f, cur_src, 64, e);
        ent.tag   = cur_tag;
        ent.err   = e;
        @(posedge clk);
        if (cur_r) begin
            q.delete();
            zero_exp = 1'b1;
        end else begin
            if (pop) void'(q.pop_front());
            if (cur_fl) q.delete();
            else if (acc) begin
                q.push_back(ent);
                zero_exp = 1'b0;
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input bit rdy);
        drive(1'b0, '0, 3'd0, 32'h0, 1'b0, rdy, 1'b0);
        step();
    endtask

    initial begin
        zero_exp = 1'b0;
        drive(1'b0, '0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        step();
        check("rst_valid", if32.out_valid_o, 0);
        check("rst_ready", if32.in_ready_o, 1);

        // Format spot checks with continuous flow.
        drive(1'b1, hi25(32'hFFF00093), 3'd0, 32'h100, 1'b0, 1'b1, 1'b0);
        step();
        check("i_valid", if32.out_valid_o, 1);
        check("i_imm", if32.imm_ext_o, 64'hFFFF_FFFF);
        check("i_err", if32.imm_err_o, 0);
        drive(1'b1, hi25(32'hFE000EE3), 3'd2, 32'h104, 1'b0, 1'b1, 1'b0);
        step();
        check("b_imm", if32.imm_ext_o, 64'hFFFF_FFFC);
        drive(1'b1, hi25(32'h000F8073), 3'd5, 32'h108, 1'b0, 1'b1, 1'b0);
        step();
        check("z_imm", if32.imm_ext_o, 64'h1F);
        drive(1'b1, hi25(32'h800000B7), 3'd4, 32'h10C, 1'b0, 1'b1, 1'b0);
        step();
        check("u_imm64", if64.imm_ext_o, 64'hFFFF_FFFF_8000_0000);
        drive(1'b1, hi25(32'h03F00013), 3'd6, 32'h110, 1'b0, 1'b1, 1'b0);
        step();
        check("sh_imm64", if64.imm_ext_o, 64'h3F);
        check("sh_imm32", if32.imm_ext_o, 64'h1F);
        drive(1'b1, hi25(32'hFFFFFFFF), 3'd7, 32'h114, 1'b0, 1'b1, 1'b0);
        step();
        check("x_imm", if64.imm_ext_o, 64'h0);
        check("x_err", if64.imm_err_o, 1);
        idle(1'b1);

        // Back-pressure: two accepted, third stalls until space opens.
        drive(1'b1, hi25(32'h00100093), 3'd0, 32'd1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, hi25(32'h00200093), 3'd0, 32'd2, 1'b0, 1'b0, 1'b0);
        step();
        check("bp_full_ready", if32.in_ready_o, 0);
        drive(1'b1, hi25(32'h00300093), 3'd0, 32'd3, 1'b0, 1'b0, 1'b0);
        step();
        check("bp_hold_tag", if32.tag_o, 32'd1);
        drive(1'b1, hi25(32'h00300093), 3'd0, 32'd3, 1'b0, 1'b1, 1'b0);
        step();
        check("bp_tag2", if32.tag_o, 32'd2);
        step();
        check("bp_tag3", if32.tag_o, 32'd3);
        idle(1'b1);
        check("bp_drained", if32.out_valid_o, 0);

        // Flush while FULL with a valid input present.
        drive(1'b1, hi25(32'h00500093), 3'd0, 32'd5, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, hi25(32'h00600093), 3'd0, 32'd6, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, hi25(32'h00700093), 3'd0, 32'hDEAD, 1'b1, 1'b0, 1'b0);
        step();
        check("fl_valid", if32.out_valid_o, 0);
        check("fl_ready", if32.in_ready_o, 1);
        idle(1'b1);
        idle(1'b1);

        // Reset while FULL.
        drive(1'b1, hi25(32'h12345093), 3'd3, 32'd8, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, hi25(32'h87654093), 3'd1, 32'd9, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, hi25(32'h00900093), 3'd0, 32'd10, 1'b1, 1'b1, 1'b1);
        step();
        check("rf_valid", if64.out_valid_o, 0);
        check("rf_imm", if64.imm_ext_o, 0);
        check("rf_tag", if64.tag_o, 0);
        idle(1'b0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, 25'($urandom), 3'($urandom), $urandom,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 59) == 0);
            step();
        end
        idle(1'b1);
        idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
